// File: rtl/seg_pattern_decoder.sv
// Active-low 7-segment pattern stream to packed hex nibble words with a valid/ready output.
// Optional dp capture into DP_OUT is built only when SEG_DP_CAPTURE_EN is defined.
module seg_pattern_decoder #(
   parameter int unsigned NUM_DIGITS = 6,
   parameter int unsigned CNT_W      = 3
) (
   input  logic                    CLOCK_50,
   input  logic                    RESET_N,
   input  logic [7:0]              SEG_IN,
   input  logic                    IN_VALID,
   output logic                    IN_READY,
   input  logic                    FLUSH,
   output logic [4*NUM_DIGITS-1:0] WORD_OUT,
   output logic [NUM_DIGITS-1:0]   DP_OUT,
   output logic                    ERR_OUT,
   output logic                    OUT_VALID,
   input  logic                    OUT_READY
);

   typedef enum logic {S_COLLECT, S_HOLD} state_t;

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [4*NUM_DIGITS-1:0] word_q, word_d;
   logic                    err_q, err_d;
   logic                    xfer, last;
   logic [3:0]              nib;
   logic                    illegal;

   assign xfer = IN_VALID && (state_q == S_COLLECT);
   assign last = (cnt_q == CNT_W'(NUM_DIGITS - 1));

   // dp (bit7) is masked so decoding is identical whether or not the dot is lit
   always_comb begin
      nib     = 4'h0;
      illegal = 1'b0;
      case (SEG_IN[6:0])
         7'h40: nib = 4'h0;
         7'h79: nib = 4'h1;
         7'h24: nib = 4'h2;
         7'h30: nib = 4'h3;
         7'h19: nib = 4'h4;
         7'h12: nib = 4'h5;
         7'h02: nib = 4'h6;
         7'h78: nib = 4'h7;
         7'h00: nib = 4'h8;
         7'h10: nib = 4'h9;
         7'h08: nib = 4'hA;
         7'h03: nib = 4'hB;
         7'h46: nib = 4'hC;
         7'h21: nib = 4'hD;
         7'h06: nib = 4'hE;
         7'h0E: nib = 4'hF;
         default: begin
            nib     = 4'h0;
            illegal = 1'b1;
         end
      endcase
   end

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= S_COLLECT;
         cnt_q   <= '0;
         word_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         word_q  <= word_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_COLLECT: if (!FLUSH && xfer && last) state_d = S_HOLD;
         S_HOLD:    if (OUT_READY) state_d = S_COLLECT;
         default:   state_d = S_COLLECT;
      endcase
   end

   always_comb begin
      cnt_d  = cnt_q;
      word_d = word_q;
      err_d  = err_q;
      if (state_q == S_HOLD) begin
         if (OUT_READY) begin
            cnt_d = '0;
            err_d = 1'b0;
         end
      end else if (FLUSH) begin
         cnt_d = '0;
         err_d = 1'b0;
      end else if (xfer) begin
         for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (cnt_q == CNT_W'(i)) word_d[4*i +: 4] = nib;
         end
         err_d = err_q | illegal;
         cnt_d = last ? cnt_q : cnt_q + CNT_W'(1);
      end
   end

`ifdef SEG_DP_CAPTURE_EN
   logic [NUM_DIGITS-1:0] dp_q, dp_d;

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) dp_q <= '0;
      else          dp_q <= dp_d;
   end

   always_comb begin
      dp_d = dp_q;
      if (state_q == S_HOLD) begin
         if (OUT_READY) dp_d = '0;
      end else if (FLUSH) begin
         dp_d = '0;
      end else if (xfer) begin
         for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (cnt_q == CNT_W'(i)) dp_d[i] = ~SEG_IN[7];
         end
      end
   end

   assign DP_OUT = dp_q;
`else
   logic unused_dp;
   assign unused_dp = SEG_IN[7];
   assign DP_OUT    = '0;
`endif

   always_comb begin
      IN_READY  = (state_q == S_COLLECT);
      OUT_VALID = (state_q == S_HOLD);
      WORD_OUT  = word_q;
      ERR_OUT   = err_q;
   end

endmodule

// File: tb/tb_seg_pattern_decoder.sv
// Directed self-checking bench for seg_pattern_decoder (NUM_DIGITS=6).
// DP expectations follow SEG_DP_CAPTURE_EN exactly as the design build does.
module tb_seg_pattern_decoder;

   logic        CLOCK_50 = 1'b0;
   logic        RESET_N;
   logic [7:0]  SEG_IN;
   logic        IN_VALID;
   logic        IN_READY;
   logic        FLUSH;
   logic [23:0] WORD_OUT;
   logic [5:0]  DP_OUT;
   logic        ERR_OUT;
   logic        OUT_VALID;
   logic        OUT_READY;

   int errors = 0;
   int checks = 0;

   seg_pattern_decoder #(.NUM_DIGITS(6), .CNT_W(3)) dut (
      .CLOCK_50 (CLOCK_50),
      .RESET_N  (RESET_N),
      .SEG_IN   (SEG_IN),
      .IN_VALID (IN_VALID),
      .IN_READY (IN_READY),
      .FLUSH    (FLUSH),
      .WORD_OUT (WORD_OUT),
      .DP_OUT   (DP_OUT),
      .ERR_OUT  (ERR_OUT),
      .OUT_VALID(OUT_VALID),
      .OUT_READY(OUT_READY)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   // Offer one pattern at a negedge, return at the negedge after it was taken.
   task automatic send(input logic [7:0] p);
      int n;
      n        = 0;
      SEG_IN   = p;
      IN_VALID = 1'b1;
      while (!IN_READY && n < 50) begin
         @(negedge CLOCK_50);
         n++;
      end
      if (!IN_READY) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: IN_READY=%b required 1", IN_READY);
      end
      @(negedge CLOCK_50);
      IN_VALID = 1'b0;
   endtask

   task automatic test_reset();
      RESET_N   = 1'b0;
      SEG_IN    = 8'hFF;
      IN_VALID  = 1'b0;
      FLUSH     = 1'b0;
      OUT_READY = 1'b0;
      repeat (2) @(negedge CLOCK_50);
      checks++; if (OUT_VALID !== 1'b0)   begin errors++; $display("FAIL rst_valid: got %b want 0", OUT_VALID); end
      checks++; if (WORD_OUT !== 24'h0)   begin errors++; $display("FAIL rst_word: got %h want 000000", WORD_OUT); end
      checks++; if (ERR_OUT !== 1'b0)     begin errors++; $display("FAIL rst_err: got %b want 0", ERR_OUT); end
      checks++; if (DP_OUT !== 6'h0)      begin errors++; $display("FAIL rst_dp: got %b want 000000", DP_OUT); end
      RESET_N = 1'b1;
      @(negedge CLOCK_50);
      checks++; if (IN_READY !== 1'b1)    begin errors++; $display("FAIL rst_ready: got %b want 1", IN_READY); end
   endtask

   task automatic test_basic();
      OUT_READY = 1'b1;
      send(8'hC0); send(8'hF9); send(8'hA4); send(8'hB0); send(8'h99);
      checks++; if (OUT_VALID !== 1'b0)   begin errors++; $display("FAIL basic_early_valid: got %b want 0", OUT_VALID); end
      send(8'h92);
      checks++; if (OUT_VALID !== 1'b1)   begin errors++; $display("FAIL basic_valid: got %b want 1", OUT_VALID); end
      checks++; if (WORD_OUT !== 24'h543210) begin errors++; $display("FAIL basic_word: got %h want 543210", WORD_OUT); end
      checks++; if (ERR_OUT !== 1'b0)     begin errors++; $display("FAIL basic_err: got %b want 0", ERR_OUT); end
      checks++; if (IN_READY !== 1'b0)    begin errors++; $display("FAIL basic_ready_hold: got %b want 0", IN_READY); end
      @(negedge CLOCK_50);
      checks++; if (OUT_VALID !== 1'b0)   begin errors++; $display("FAIL basic_release: got %b want 0", OUT_VALID); end
      checks++; if (IN_READY !== 1'b1)    begin errors++; $display("FAIL basic_ready_after: got %b want 1", IN_READY); end
      checks++; if (WORD_OUT !== 24'h543210) begin errors++; $display("FAIL basic_word_kept: got %h want 543210", WORD_OUT); end
   endtask

   task automatic test_hold();
      OUT_READY = 1'b0;
      send(8'h88); send(8'h83); send(8'hC6); send(8'hA1); send(8'h86); send(8'h8E);
      SEG_IN   = 8'hC0;
      IN_VALID = 1'b1;
      for (int i = 0; i < 5; i++) begin
         checks++; if (OUT_VALID !== 1'b1)      begin errors++; $display("FAIL hold_valid[%0d]: got %b want 1", i, OUT_VALID); end
         checks++; if (WORD_OUT !== 24'hFEDCBA) begin errors++; $display("FAIL hold_word[%0d]: got %h want FEDCBA", i, WORD_OUT); end
         checks++; if (IN_READY !== 1'b0)       begin errors++; $display("FAIL hold_ready[%0d]: got %b want 0", i, IN_READY); end
         @(negedge CLOCK_50);
      end
      OUT_READY = 1'b1;
      @(negedge CLOCK_50);
      checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL hold_release: got %b want 0", OUT_VALID); end
      send(8'hC0);
      send(8'hF9); send(8'hF9); send(8'hF9); send(8'hF9); send(8'hF9);
      checks++; if (WORD_OUT !== 24'h111110) begin errors++; $display("FAIL hold_next_word: got %h want 111110", WORD_OUT); end
   endtask

   task automatic test_error();
      OUT_READY = 1'b1;
      send(8'hC0); send(8'hFF); send(8'hC0); send(8'hC0); send(8'hC0); send(8'hC0);
      checks++; if (WORD_OUT !== 24'h000000) begin errors++; $display("FAIL err_word: got %h want 000000", WORD_OUT); end
      checks++; if (ERR_OUT !== 1'b1)        begin errors++; $display("FAIL err_flag: got %b want 1", ERR_OUT); end
      for (int i = 0; i < 6; i++) send(8'hF9);
      checks++; if (WORD_OUT !== 24'h111111) begin errors++; $display("FAIL err_next_word: got %h want 111111", WORD_OUT); end
      checks++; if (ERR_OUT !== 1'b0)        begin errors++; $display("FAIL err_cleared: got %b want 0", ERR_OUT); end
   endtask

   task automatic test_flush();
      OUT_READY = 1'b1;
      send(8'hF9); send(8'hA4); send(8'hB0);
      SEG_IN   = 8'h99;
      IN_VALID = 1'b1;
      FLUSH    = 1'b1;
      @(negedge CLOCK_50);
      FLUSH    = 1'b0;
      IN_VALID = 1'b0;
      checks++; if (IN_READY !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b want 1", IN_READY); end
      OUT_READY = 1'b0;
      for (int i = 0; i < 6; i++) send(8'hF8);
      checks++; if (WORD_OUT !== 24'h777777) begin errors++; $display("FAIL flush_word: got %h want 777777", WORD_OUT); end
      FLUSH = 1'b1;
      @(negedge CLOCK_50);
      FLUSH = 1'b0;
      checks++; if (OUT_VALID !== 1'b1)      begin errors++; $display("FAIL flush_hold_valid: got %b want 1", OUT_VALID); end
      checks++; if (WORD_OUT !== 24'h777777) begin errors++; $display("FAIL flush_hold_word: got %h want 777777", WORD_OUT); end
      OUT_READY = 1'b1;
      @(negedge CLOCK_50);
   endtask

   task automatic test_dp();
      logic [5:0] dp_exp;
`ifdef SEG_DP_CAPTURE_EN
      dp_exp = 6'b010101;
`else
      dp_exp = 6'b000000;
`endif
      OUT_READY = 1'b1;
      send(8'h40); send(8'hF9); send(8'h40); send(8'hF9); send(8'h40); send(8'hF9);
      checks++; if (WORD_OUT !== 24'h101010) begin errors++; $display("FAIL dp_word: got %h want 101010", WORD_OUT); end
      checks++; if (DP_OUT !== dp_exp)       begin errors++; $display("FAIL dp_bits: got %b want %b", DP_OUT, dp_exp); end
      checks++; if (ERR_OUT !== 1'b0)        begin errors++; $display("FAIL dp_err: got %b want 0", ERR_OUT); end
      @(negedge CLOCK_50);
      checks++; if (DP_OUT !== 6'h0)         begin errors++; $display("FAIL dp_cleared: got %b want 000000", DP_OUT); end
   endtask

   task automatic test_reset_mid_hold();
      OUT_READY = 1'b0;
      for (int i = 0; i < 6; i++) send(8'h92);
      checks++; if (WORD_OUT !== 24'h555555) begin errors++; $display("FAIL mid_pre_word: got %h want 555555", WORD_OUT); end
      #2 RESET_N = 1'b0;
      #1;
      checks++; if (OUT_VALID !== 1'b0)      begin errors++; $display("FAIL mid_valid: got %b want 0", OUT_VALID); end
      checks++; if (WORD_OUT !== 24'h000000) begin errors++; $display("FAIL mid_word: got %h want 000000", WORD_OUT); end
      @(negedge CLOCK_50);
      RESET_N   = 1'b1;
      OUT_READY = 1'b1;
      @(negedge CLOCK_50);
      send(8'h99);
      for (int i = 0; i < 5; i++) send(8'hF9);
      checks++; if (OUT_VALID !== 1'b1)      begin errors++; $display("FAIL mid_new_valid: got %b want 1", OUT_VALID); end
      checks++; if (WORD_OUT !== 24'h111114) begin errors++; $display("FAIL mid_new_word: got %h want 111114", WORD_OUT); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_hold();
      test_error();
      test_flush();
      test_dp();
      test_reset_mid_hold();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/seg_pattern_decoder.md
Name: seg_pattern_decoder

Overview:
- Receiver-side counterpart to the team's switch-to-7-segment encoder: accepts a stream of active-low 7-segment byte patterns and recovers the hex digits they display.
- Decodes each pattern to a 4-bit nibble and packs NUM_DIGITS nibbles into one word.
- Presents the word on a valid/ready output; used by self-check logic and loopback tests that read back HEX-bus traffic.

Parameters:
- NUM_DIGITS, default 6, number of digits packed per output word (HEX0..HEX5); legal range 1..8.
- CNT_W, default 3, digit-counter width; must satisfy 2**CNT_W >= NUM_DIGITS.

Ports:
- CLOCK_50  input  1  system clock; all logic on rising edge.
- RESET_N  input  1  asynchronous active-low reset.
- SEG_IN  input  8  segment pattern, active-low; bit7=dp, bit6=g, bit5=f, bit4=e, bit3=d, bit2=c, bit1=b, bit0=a.
- IN_VALID  input  1  SEG_IN holds a pattern.
- IN_READY  output  1  block accepts a pattern this cycle.
- FLUSH  input  1  synchronous abort of the partial word.
- WORD_OUT  output  4*NUM_DIGITS  packed nibbles; digit 0 in [3:0].
- DP_OUT  output  NUM_DIGITS  captured decimal points, 1 = lit (see Optional Feature).
- ERR_OUT  output  1  at least one pattern in WORD_OUT was illegal.
- OUT_VALID  output  1  WORD_OUT, DP_OUT and ERR_OUT are valid.
- OUT_READY  input  1  consumer accepts the word.

Behaviour:
- Reset is asynchronous and active-low; the clock is the single CLOCK_50 domain.
- Reset values:
  - State = COLLECT, digit count = 0.
  - WORD_OUT = 0, DP_OUT = 0, ERR_OUT = 0, OUT_VALID = 0.
  - IN_READY = 1 once RESET_N deasserts.
- Decode:
  - Mask bit7 (dp) before lookup.
  - Lookup table: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E (values shown with dp off).
  - Any other pattern, including all-dark FF, is illegal: store nibble 0 and set the sticky error flag.
- Handshake: a transfer occurs when IN_VALID && IN_READY. IN_READY is 1 only in COLLECT.
- COLLECT state:
  - On each transfer, write the decoded nibble into slot [count] and increment count.
  - The transfer with count == NUM_DIGITS-1 moves the FSM to HOLD.
  - OUT_VALID rises on the next cycle, giving 1-cycle latency from the final accepted pattern.
- HOLD state:
  - OUT_VALID = 1 and IN_READY = 0.
  - WORD_OUT, DP_OUT and ERR_OUT stay stable until OUT_VALID && OUT_READY.
  - On that cycle: go to COLLECT, count = 0, error flag cleared; OUT_VALID = 0 next cycle.
  - WORD_OUT keeps its last value; it is not cleared.
  - A pattern offered during HOLD is not taken; the producer must keep it on SEG_IN.
- OUT_READY held at 1 gives a back-to-back throughput of NUM_DIGITS+1 cycles per word.
- FLUSH:
  - In COLLECT: count = 0, error flag cleared, partial nibbles discarded. FLUSH has priority over a transfer in the same cycle; that pattern is dropped.
  - In HOLD: ignored. A completed word is never lost.
- Reset mid-word or mid-HOLD: state returns to reset values immediately; the pending word is lost.
- Count never exceeds NUM_DIGITS-1 in COLLECT; there is no wrap except through HOLD.

Optional Feature:
- Macro: SEG_DP_CAPTURE_EN.
- Defined: on each transfer, DP_OUT[count] = ~SEG_IN[7]; DP_OUT is cleared together with the count on word release or FLUSH.
- Undefined: no dp storage is built, DP_OUT is tied to 0, and SEG_IN[7] is ignored entirely.
- Nibble decode and error detection are identical in both builds.

Test Plan:
- Reset then six transfers C0, F9, A4, B0, 99, 92 with OUT_READY=1 -> OUT_VALID=1 one cycle after the 6th transfer, WORD_OUT=0x543210, ERR_OUT=0, then IN_READY=1 the following cycle.
- Sequence 88, 83, C6, A1, 86, 8E with OUT_READY=0 for 5 cycles -> WORD_OUT=0xFEDCBA held stable, IN_READY=0 throughout HOLD; the pattern offered during HOLD is accepted only after release.
- Sequence C0, FF, C0, C0, C0, C0 -> WORD_OUT=0x000000, ERR_OUT=1; the next legal word 11,11... (F9 x6) -> WORD_OUT=0x111111, ERR_OUT=0.
- Three transfers F9, A4, B0, then FLUSH asserted together with IN_VALID on 99, then six F8 -> WORD_OUT=0x777777; the 99 is dropped.
- SEG_DP_CAPTURE_EN defined, sequence 40, F9, 40, F9, 40, F9 -> WORD_OUT=0x101010, DP_OUT=6'b010101. Undefined, same sequence -> DP_OUT=0, same WORD_OUT.
- RESET_N pulsed low mid-HOLD -> OUT_VALID=0 and WORD_OUT=0 asynchronously; the next six transfers form a fresh word starting at slot 0.
